// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator result monitor.
package cmp_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        ARMING   = 2'd1,
        ALARM    = 2'd2,
        CLEARING = 2'd3
    } state_t;

    localparam int RUN_W = 8;

    // Bit positions follow the comparator's y0/y1/y2 output ordering.
    localparam int GT = 0;
    localparam int EQ = 1;
    localparam int LT = 2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping; clr has priority.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cmp_result_monitor.sv
// Counts one-hot comparator results, flags non-one-hot samples and raises a
// hysteretic alarm on runs of a>b results.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// NORMAL   | no alarm, no a>b run in progress
// ARMING   | counting consecutive a>b samples toward TRIP_LEN
// ALARM    | alarm asserted, a>b still being seen
// CLEARING | alarm asserted, counting non-a>b samples toward CLEAR_LEN
module cmp_result_monitor
    import cmp_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int TRIP_LEN  = 4,
    parameter int CLEAR_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_gt,
    input  logic             in_eq,
    input  logic             in_lt,
    input  logic             clr,
    output logic             alarm,
    output logic             alarm_rise,
    output logic             err,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [7:0]       run_len
);

    state_t          state;
    logic [2:0]      flags;
    logic            one_hot;
    logic            accept;
    logic            bad;
    logic [RUN_W-1:0] run_nxt;

    always_comb begin
        flags          = 3'b000;
        flags[GT]      = in_gt;
        flags[EQ]      = in_eq;
        flags[LT]      = in_lt;
        one_hot        = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
        accept         = in_valid && one_hot && !clr;
        bad            = in_valid && !one_hot;
        run_nxt        = run_len + RUN_W'(1);
    end

    sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
        .clk(clk), .rst_n(rst_n), .inc(accept && flags[GT]), .clr(clr), .cnt(gt_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
        .clk(clk), .rst_n(rst_n), .inc(accept && flags[EQ]), .clr(clr), .cnt(eq_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
        .clk(clk), .rst_n(rst_n), .inc(accept && flags[LT]), .clr(clr), .cnt(lt_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORMAL;
            run_len    <= '0;
            alarm      <= 1'b0;
            alarm_rise <= 1'b0;
            err        <= 1'b0;
        end else if (clr) begin
            state      <= NORMAL;
            run_len    <= '0;
            alarm      <= 1'b0;
            alarm_rise <= 1'b0;
            err        <= 1'b0;
        end else begin
            alarm_rise <= 1'b0;
            if (bad) begin
                err <= 1'b1;
            end
            if (accept) begin
                case (state)
                    NORMAL: begin
                        if (flags[GT]) begin
                            if (TRIP_LEN == 1) begin
                                state      <= ALARM;
                                run_len    <= '0;
                                alarm      <= 1'b1;
                                alarm_rise <= 1'b1;
                            end else begin
                                state   <= ARMING;
                                run_len <= RUN_W'(1);
                            end
                        end
                    end
                    ARMING: begin
                        if (!flags[GT]) begin
                            state   <= NORMAL;
                            run_len <= '0;
                        end else if (run_nxt == RUN_W'(TRIP_LEN)) begin
                            state      <= ALARM;
                            run_len    <= '0;
                            alarm      <= 1'b1;
                            alarm_rise <= 1'b1;
                        end else begin
                            run_len <= run_nxt;
                        end
                    end
                    ALARM: begin
                        if (!flags[GT]) begin
                            if (CLEAR_LEN == 1) begin
                                state   <= NORMAL;
                                run_len <= '0;
                                alarm   <= 1'b0;
                            end else begin
                                state   <= CLEARING;
                                run_len <= RUN_W'(1);
                            end
                        end
                    end
                    CLEARING: begin
                        // A single a>b sample re-arms the alarm without a new rise pulse.
                        if (flags[GT]) begin
                            state   <= ALARM;
                            run_len <= '0;
                        end else if (run_nxt == RUN_W'(CLEAR_LEN)) begin
                            state   <= NORMAL;
                            run_len <= '0;
                            alarm   <= 1'b0;
                        end else begin
                            run_len <= run_nxt;
                        end
                    end
                    default: begin
                        state   <= NORMAL;
                        run_len <= '0;
                        alarm   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Bench for cmp_result_monitor: directed vector table, corner sequences and
// randomized traffic against a streak-based reference model.
module tb_cmp_result_monitor;

    localparam int CNT_W     = 4;
    localparam int TRIP_LEN  = 4;
    localparam int CLEAR_LEN = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_gt;
    logic             in_eq;
    logic             in_lt;
    logic             clr;
    logic             alarm;
    logic             alarm_rise;
    logic             err;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [7:0]       run_len;

    int checks;
    int errors;

    cmp_result_monitor #(
        .CNT_W(CNT_W), .TRIP_LEN(TRIP_LEN), .CLEAR_LEN(CLEAR_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_gt(in_gt),
        .in_eq(in_eq), .in_lt(in_lt), .clr(clr), .alarm(alarm),
        .alarm_rise(alarm_rise), .err(err), .gt_cnt(gt_cnt), .eq_cnt(eq_cnt),
        .lt_cnt(lt_cnt), .run_len(run_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic v, g, e, l, c;
        int   alarm, rise, err, gt, eq, lt, run;
    } vec_t;

    vec_t tbl[$];

    // Reference model: tracks streak lengths of consecutive a>b / non-a>b samples.
    int  m_gt, m_eq, m_lt, m_err, m_alarm, m_rise, gs, ns;

    function automatic vec_t mk(logic v, logic g, logic e, logic l, logic c,
                                int a, int r, int er, int gc, int ec, int lc, int rl);
        vec_t t;
        t.v = v; t.g = g; t.e = e; t.l = l; t.c = c;
        t.alarm = a; t.rise = r; t.err = er; t.gt = gc; t.eq = ec; t.lt = lc; t.run = rl;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gt = 0; m_eq = 0; m_lt = 0; m_err = 0; m_alarm = 0; m_rise = 0; gs = 0; ns = 0;
    endtask

    task automatic model_step(input logic v, input logic g, input logic e,
                              input logic l, input logic c);
        if (c) begin
            model_reset();
        end else begin
            m_rise = 0;
            if (v) begin
                if (int'(g) + int'(e) + int'(l) == 1) begin
                    if (g) m_gt = (m_gt < CNT_MAX) ? m_gt + 1 : CNT_MAX;
                    if (e) m_eq = (m_eq < CNT_MAX) ? m_eq + 1 : CNT_MAX;
                    if (l) m_lt = (m_lt < CNT_MAX) ? m_lt + 1 : CNT_MAX;
                    if (g) begin
                        gs = (gs < 1000) ? gs + 1 : 1000;
                        ns = 0;
                        if (m_alarm == 0 && gs >= TRIP_LEN) begin
                            m_alarm = 1;
                            m_rise  = 1;
                        end
                    end else begin
                        ns = (ns < 1000) ? ns + 1 : 1000;
                        gs = 0;
                        if (m_alarm == 1 && ns >= CLEAR_LEN) m_alarm = 0;
                    end
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    function automatic int model_run();
        if (m_alarm == 1) return (ns < CLEAR_LEN) ? ns : 0;
        return (gs < TRIP_LEN) ? gs : 0;
    endfunction

    task automatic drive(input logic v, input logic g, input logic e,
                         input logic l, input logic c);
        in_valid = v; in_gt = g; in_eq = e; in_lt = l; clr = c;
        model_step(v, g, e, l, c);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " alarm"},      int'(alarm),      m_alarm);
        chk({tag, " alarm_rise"}, int'(alarm_rise), m_rise);
        chk({tag, " err"},        int'(err),        m_err);
        chk({tag, " gt_cnt"},     int'(gt_cnt),     m_gt);
        chk({tag, " eq_cnt"},     int'(eq_cnt),     m_eq);
        chk({tag, " lt_cnt"},     int'(lt_cnt),     m_lt);
        chk({tag, " run_len"},    int'(run_len),    model_run());
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " alarm"},      int'(alarm),      0);
        chk({tag, " alarm_rise"}, int'(alarm_rise), 0);
        chk({tag, " err"},        int'(err),        0);
        chk({tag, " gt_cnt"},     int'(gt_cnt),     0);
        chk({tag, " eq_cnt"},     int'(eq_cnt),     0);
        chk({tag, " lt_cnt"},     int'(lt_cnt),     0);
        chk({tag, " run_len"},    int'(run_len),    0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 0; in_gt = 0; in_eq = 0; in_lt = 0; clr = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 0; in_gt = 0; in_eq = 0; in_lt = 0; clr = 0;
        model_reset();

        // Directed table: trip, broken run, clearing with re-arm, error flag.
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 1,0,0, 1));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 2,0,0, 2));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 3,0,0, 3));
        tbl.push_back(mk(1,1,0,0,0, 1,1,0, 4,0,0, 0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0, 4,0,0, 0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0, 0,0,0, 0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 1,0,0, 1));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 2,0,0, 2));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 3,0,0, 3));
        tbl.push_back(mk(1,0,1,0,0, 0,0,0, 3,1,0, 0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 4,1,0, 1));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 5,1,0, 2));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 6,1,0, 3));
        tbl.push_back(mk(1,1,0,0,0, 1,1,0, 7,1,0, 0));
        tbl.push_back(mk(1,0,0,1,0, 1,0,0, 7,1,1, 1));
        tbl.push_back(mk(1,0,0,1,0, 1,0,0, 7,1,2, 2));
        tbl.push_back(mk(1,1,0,0,0, 1,0,0, 8,1,2, 0));
        tbl.push_back(mk(1,0,0,1,0, 1,0,0, 8,1,3, 1));
        tbl.push_back(mk(1,0,0,1,0, 1,0,0, 8,1,4, 2));
        tbl.push_back(mk(1,0,0,1,0, 1,0,0, 8,1,5, 3));
        tbl.push_back(mk(1,0,0,1,0, 0,0,0, 8,1,6, 0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 9,1,6, 1));
        tbl.push_back(mk(1,1,0,1,0, 0,0,1, 9,1,6, 1));
        tbl.push_back(mk(1,0,0,0,0, 0,0,1, 9,1,6, 1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1, 9,1,6, 1));
        tbl.push_back(mk(1,1,0,0,0, 0,0,1, 10,1,6, 2));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0, 0,0,0, 0));

        #23;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].v, tbl[i].g, tbl[i].e, tbl[i].l, tbl[i].c);
            chk({tag, " alarm"},      int'(alarm),      tbl[i].alarm);
            chk({tag, " alarm_rise"}, int'(alarm_rise), tbl[i].rise);
            chk({tag, " err"},        int'(err),        tbl[i].err);
            chk({tag, " gt_cnt"},     int'(gt_cnt),     tbl[i].gt);
            chk({tag, " eq_cnt"},     int'(eq_cnt),     tbl[i].eq);
            chk({tag, " lt_cnt"},     int'(lt_cnt),     tbl[i].lt);
            chk({tag, " run_len"},    int'(run_len),    tbl[i].run);
        end

        // Saturation of eq_cnt, then clr beating a same-cycle gt sample.
        for (int i = 1; i <= 20; i++) begin
            drive(1, 0, 1, 0, 0);
            chk("sat eq_cnt", int'(eq_cnt), (i > 15) ? 15 : i);
        end
        drive(1, 1, 0, 0, 1);
        check_zero("clr_vs_gt");
        drive(0, 0, 0, 0, 0);
        chk("clr_vs_gt idle gt_cnt", int'(gt_cnt), 0);

        // Async reset mid-ARMING.
        do_reset();
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        chk("arming run_len", int'(run_len), 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("async_rst_arming");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        check_zero("post_rst_arming");

        // Async reset while alarm is high.
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0);
        chk("alarm before rst", int'(alarm), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("async_rst_alarm");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        check_zero("post_rst_alarm");
        drive(1, 0, 1, 0, 0);
        chk("post_rst rise", int'(alarm_rise), 0);

        // Randomized traffic against the streak model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic v, g, e, l, c;
            int   sel;
            logic [2:0] rnd;
            v   = ($urandom_range(0, 9) < 8);
            sel = int'($urandom_range(0, 19));
            rnd = 3'($urandom);
            g = 0; e = 0; l = 0;
            if (sel <= 8)       g = 1;
            else if (sel <= 12) e = 1;
            else if (sel <= 16) l = 1;
            else begin g = rnd[0]; e = rnd[1]; l = rnd[2]; end
            c = ($urandom_range(0, 59) == 0);
            drive(v, g, e, l, c);
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
